// File: rtl/rca_bist_reconfig_ctrl_pkg.sv
// rca_bist_pkg: FSM states, adder select configuration type and the reconfiguration ROM
package rca_bist_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DECIDE, FINISH} state_t;

    typedef struct packed {
        logic [2:0] is0;
        logic [2:0] is1;
        logic [4:0] cs;
        logic [3:0] ss0;
        logic [3:0] ss1;
    } cfg_t;

    localparam logic [3:0] IDX_P01 = 4'd5;
    localparam logic [3:0] IDX_P02 = 4'd6;
    localparam logic [3:0] IDX_P03 = 4'd7;
    localparam logic [3:0] IDX_P12 = 4'd8;
    localparam logic [3:0] IDX_P13 = 4'd9;
    localparam logic [3:0] IDX_P23 = 4'd10;

    // is0/is1: 1 + logical bit steered onto spare 4/5; cs: bypassed primaries (bit 4 = plain ripple);
    // ss0/ss1: logical sum bits taken from spare 4/5
    localparam cfg_t CFG_ROM [0:10] = '{
        {3'd0, 3'd0, 5'b10000, 4'b0000, 4'b0000},
        {3'd1, 3'd0, 5'b00001, 4'b0001, 4'b0000},
        {3'd2, 3'd0, 5'b00010, 4'b0010, 4'b0000},
        {3'd3, 3'd0, 5'b00100, 4'b0100, 4'b0000},
        {3'd4, 3'd0, 5'b01000, 4'b1000, 4'b0000},
        {3'd1, 3'd2, 5'b00011, 4'b0001, 4'b0010},
        {3'd1, 3'd3, 5'b00101, 4'b0001, 4'b0100},
        {3'd1, 3'd4, 5'b01001, 4'b0001, 4'b1000},
        {3'd2, 3'd3, 5'b00110, 4'b0010, 4'b0100},
        {3'd2, 3'd4, 5'b01010, 4'b0010, 4'b1000},
        {3'd3, 3'd4, 5'b01100, 4'b0100, 4'b1000}
    };

    function automatic logic [3:0] cfg_idx(input logic [3:0] f);
        case (f)
            4'b0001: return 4'd1;
            4'b0010: return 4'd2;
            4'b0100: return 4'd3;
            4'b1000: return 4'd4;
            4'b0011: return IDX_P01;
            4'b0101: return IDX_P02;
            4'b1001: return IDX_P03;
            4'b0110: return IDX_P12;
            4'b1010: return IDX_P13;
            4'b1100: return IDX_P23;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/rca_bist_reconfig_ctrl_if.sv
// rca_bist_reconfig_ctrl_if: BIST controller <-> adder test port and reconfiguration bus
interface rca_bist_reconfig_ctrl_if;

    logic       start;
    logic [3:0] adder_sums;
    logic [3:0] adder_carrys;
    logic       test;
    logic [3:0] at;
    logic [3:0] bt;
    logic       cint;
    logic [2:0] is0;
    logic [2:0] is1;
    logic [4:0] cs;
    logic [3:0] ss0;
    logic [3:0] ss1;
    logic [3:0] fault_map;
    logic       busy;
    logic       done;
    logic       uncorrectable;

    modport master (
        input  start, adder_sums, adder_carrys,
        output test, at, bt, cint, is0, is1, cs, ss0, ss1, fault_map, busy, done, uncorrectable
    );

    modport slave (
        output start, adder_sums, adder_carrys,
        input  test, at, bt, cint, is0, is1, cs, ss0, ss1, fault_map, busy, done, uncorrectable
    );

endinterface

// File: rtl/rca_bist_reconfig_ctrl_fa_check.sv
// rca_fa_check: per-adder sum/carry mismatch using each adder's observed upstream carry
module rca_fa_check (
    input  logic [3:0] i_at,
    input  logic [3:0] i_bt,
    input  logic       i_cint,
    input  logic [3:0] i_sums,
    input  logic [3:0] i_carrys,
    output logic [3:0] o_mismatch
);

    logic [3:0] w_cin;

    assign w_cin      = {i_carrys[2:0], i_cint};
    assign o_mismatch = (i_sums ^ (i_at ^ i_bt ^ w_cin))
                      | (i_carrys ^ ((i_at & i_bt) | (i_at & w_cin) | (i_bt & w_cin)));

endmodule

// File: rtl/rca_bist_reconfig_ctrl.sv
// rca_bist_reconfig_ctrl: BIST sweep of the four primary full adders and spare-routing reconfiguration
module rca_bist_reconfig_ctrl
    import rca_bist_pkg::*;
#(
    parameter int SWEEP_LEN = 512
) (
    input  logic clk,
    input  logic rst,
    rca_bist_reconfig_ctrl_if.master bus
);

    state_t     r_state, w_next;
    logic [8:0] r_pat;
    logic       r_test, r_busy, r_done, r_uncorr;
    logic [3:0] r_fault, w_mism;
    cfg_t       r_cfg;
    logic       w_last, w_over;

    rca_fa_check u_check (
        .i_at       (r_pat[3:0]),
        .i_bt       (r_pat[7:4]),
        .i_cint     (r_pat[8]),
        .i_sums     (bus.adder_sums),
        .i_carrys   (bus.adder_carrys),
        .o_mismatch (w_mism)
    );

    always_comb begin
        w_last = r_pat == 9'(SWEEP_LEN - 1);
        w_over = $countones(r_fault) > 2;
        w_next = (r_state == IDLE)   ? (bus.start ? SWEEP : IDLE) :
                 (r_state == SWEEP)  ? (w_last ? DECIDE : SWEEP) :
                 (r_state == DECIDE) ? FINISH : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pat    <= '0;
            r_test   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_uncorr <= 1'b0;
            r_fault  <= '0;
            r_cfg    <= CFG_ROM[0];
        end else begin
            r_state <= w_next;
            r_test  <= w_next == SWEEP;
            r_busy  <= w_next == SWEEP || w_next == DECIDE;
            r_done  <= w_next == FINISH;
            r_pat   <= (r_state == SWEEP && w_next == SWEEP) ? r_pat + 9'd1 : '0;
            if (r_state == IDLE && bus.start) begin
                r_fault  <= '0;
                r_uncorr <= 1'b0;
            end
            if (r_state == SWEEP)
                r_fault <= r_fault | w_mism;
            if (r_state == DECIDE) begin
                if (w_over)
                    r_uncorr <= 1'b1;
                else
                    r_cfg <= CFG_ROM[cfg_idx(r_fault)];
            end
        end
    end

    assign bus.test          = r_test;
    assign bus.at            = r_pat[3:0];
    assign bus.bt            = r_pat[7:4];
    assign bus.cint          = r_pat[8];
    assign bus.is0           = r_cfg.is0;
    assign bus.is1           = r_cfg.is1;
    assign bus.cs            = r_test ? 5'b00000 : r_cfg.cs;
    assign bus.ss0           = r_cfg.ss0;
    assign bus.ss1           = r_cfg.ss1;
    assign bus.fault_map     = r_fault;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.uncorrectable = r_uncorr;

endmodule

// File: doc/rca_bist_reconfig_ctrl.md
Name: rca_bist_reconfig_ctrl

Overview:
Built-in self-test and reconfiguration controller for the double-fault-tolerant 4-bit ripple-carry adder. It drives the adder's test port and sweeps patterns across all four primary full adders. It reads back the per-adder sum and carry observation outputs and marks each primary adder as faulty or good. It then programs the five adder select buses (is0, is1, cs, ss0, ss1) so that logical bits route around up to two faulty adders.

Parameters:
SWEEP_LEN, 512, number of test patterns applied; legal range 2..512. Pattern p drives {cint, bt, at} = p[8:0], zero-extended.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request a self-test sweep; sampled only in IDLE
adder_sums  in  4  observed fa_sum of primary adders 0..3
adder_carrys  in  4  observed fa_carry of primary adders 0..3
test  out  1  adder test-mode select
at  out  4  test operand A
bt  out  4  test operand B
cint  out  1  test carry-in
is0  out  3  stage-0 input select
is1  out  3  stage-1 input select
cs  out  5  carry select
ss0  out  4  stage-0 sum select
ss1  out  4  stage-1 sum select
fault_map  out  4  sticky per-adder fault flags; bit k = primary adder k
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when a sweep ends
uncorrectable  out  1  more than two faults were found

Behaviour:
- Clocking and reset:
  - Single clock; synchronous active-high reset.
  - All outputs are registered except cs.
- Reset values:
  - test=0, at=0, bt=0, cint=0.
  - fault_map=0, busy=0, done=0, uncorrectable=0.
  - Configuration = CFG_ROM[0] (no fault): is0=000, is1=000, cs=10000, ss0=0000, ss1=0000.
- FSM states: IDLE, SWEEP, DECIDE, FINISH.
- IDLE:
  - test=0.
  - start=1 moves to SWEEP on the next edge.
  - On entry to SWEEP: fault_map and uncorrectable clear; pattern counter = 0.
- SWEEP:
  - busy=1, test=1.
  - {cint, bt, at} = counter, held for one cycle per pattern.
  - cs output is forced to 00000 while test=1. The carry inputs are then: fa0 gets cint, fa1 gets carry0, fa2 gets carry1, fa3 gets carry2.
  - Same-cycle check for each adder k: expected_sum = at[k]^bt[k]^cin_k and expected_carry = maj(at[k], bt[k], cin_k).
  - cin_k is cint for k=0 and adder_carrys[k-1] otherwise. Using the observed upstream carry keeps the check local to one adder.
  - Any mismatch sets fault_map[k] at the next edge; fault flags are sticky.
  - The counter increments each cycle. At counter = SWEEP_LEN-1, the next state is DECIDE.
  - start is ignored while busy.
- DECIDE (one cycle):
  - busy=1, test=0.
  - popcount(fault_map) = 0 gives idx 0.
  - Exactly one fault at adder k gives idx 1+k.
  - Two faults give idx 5..10 for pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3), in that order.
  - In all of these cases the configuration registers load CFG_ROM[idx].
  - More than two faults: configuration registers hold their prior values and uncorrectable=1.
- FINISH (one cycle): done=1, busy=0, then return to IDLE.
- Latency: if start is sampled at edge T, done is high during cycle T+SWEEP_LEN+2.
- Spare adders 4 and 5 are not observable and are treated as good.
- The adder is combinational, so no settle cycles are inserted.
- Reset mid-sweep: the state returns to IDLE and all outputs take reset values at that edge. Partial fault_map contents are discarded.
- A new sweep after a completed one re-derives the configuration from scratch.

Decomposition:
- Package rca_bist_pkg contains:
  - the state enum;
  - a packed cfg_t struct {is0[3], is1[3], cs[5], ss0[4], ss1[4]}, 19 bits;
  - CFG_ROM[0:10] of cfg_t, with entry 0 = the reset configuration above;
  - the pair-to-index constants.
- Sub-module rca_fa_check: purely combinational. It takes at, bt, cint, adder_sums and adder_carrys and produces a 4-bit mismatch vector.

Test Plan:
- Fault-free adder model, start pulsed: test=1 for 512 cycles, done at T+514. Result: fault_map=0000, cs=10000, is0=is1=000, ss0=ss1=0000, uncorrectable=0.
- fa2 sum stuck-at-0: fault_map=0100 and configuration = CFG_ROM[3]. Additionally at=0100, bt=0000, cint=0 must set the flag at the following edge.
- fa0 carry stuck-at-1 plus fa3 sum stuck-at-1: fault_map=1001, configuration = CFG_ROM[7], uncorrectable=0.
- fa0, fa1 and fa2 all stuck: fault_map=0111, uncorrectable=1, configuration unchanged from its pre-sweep value.
- rst asserted at pattern 100, with start held high throughout: the next edge gives test=0, busy=0 and configuration = CFG_ROM[0]. A start pulse during SWEEP is ignored and does not lengthen the sweep.
- SWEEP_LEN=8, fault-free: done arrives exactly 10 cycles after start is sampled, and bt and cint stay 0 throughout.
